interrupt_controller: RTL
=========================

# interrupt_controller

Receiving end of the peripheral interrupt lines: captures request pulses from the timers (INT 0x50), video, serial and joypad blocks, and holds them in IF (0xFF0F) and IE (0xFFFF). Owns the master enable IME. Arbitrates by fixed priority and presents a vector-request/acknowledge handshake to the CPU at instruction boundaries. Sits between the peripherals and the CPU control unit, with its registers on the MCU register bus.

## Interface
- No parameters.
- iClock  in  1  system clock; all state updates on posedge.
- iReset  in  1  synchronous, active-high reset.
- iVBlank  in  1  VBlank request (IF bit 0, vector 0x40).
- iLcdStat  in  1  LCD STAT request (bit 1, 0x48).
- iTimer  in  1  timer overflow request, from oInterrupt0x50 (bit 2, 0x50).
- iSerial  in  1  serial request (bit 3, 0x58).
- iJoypad  in  1  joypad request (bit 4, 0x60).
- iMcuWeIf  in  1  write strobe for IF.
- iMcuWeIe  in  1  write strobe for IE.
- iMcuWriteData  in  8  MCU write data.
- iEof  in  1  end-of-instruction strobe from the CPU, one cycle.
- iEi, iDi, iReti  in  1 each  one-cycle strobes issued while the CPU executes EI / DI / RETI.
- iIrqAck  in  1  CPU accepts the dispatch.
- oIf  out  8  IF readback: {3'b111, rIf[4:0]}.
- oIe  out  8  IE readback, all 8 bits stored.
- oIme  out  1  current master enable.
- oIrqPending  out  1  |(rIf[4:0] & oIe[4:0]), independent of IME; wakes the CPU from HALT.
- oIrqReq  out  1  dispatch request to the CPU.
- oVector  out  8  dispatch target address.

## Operation
- **Edge capture**
  - Each source is registered every cycle.
  - A 0→1 transition (input high, previous sample low) sets the matching rIf bit.
  - A source held high sets its bit once only.
- **IF/IE writes**
  - IF write: rIf <= iMcuWriteData[4:0].
  - IE write: all 8 bits are stored.
- **Update priority for rIf within one cycle**, lowest to highest: MCU write, ack clear, hardware set. A hardware set always wins.
- **Arbitration**
  - Highest priority pending bit = lowest index set in rIf & IE[4:0].
  - Vector = 0x40 + 8*index.
- **IME**
  - iDi: IME <= 0 and the EI-pending flag <= 0.
  - iReti: IME <= 1.
  - iEi: sets the EI-pending flag. IME <= 1 on the second iEof after iEi (the iEof closing EI does not count), so that the instruction following EI completes first.
  - Ack: IME <= 0.
  - iDi beats iEi/iReti in the same cycle.
- **FSM states**
  - IC_IDLE: oIrqReq=0, oVector=0x00.
    - If IME & oIrqPending & iEof, go to IC_REQ.
  - IC_REQ: oIrqReq=1, oVector = live arbitration result.
    - On iIrqAck: clear the selected rIf bit, clear IME, latch the vector, go to IC_SERVICE.
    - If pending drops to 0 without ack (software cleared IF/IE), go to IC_IDLE.
  - IC_SERVICE: oIrqReq=0, oVector = latched vector.
    - On iEof (end of dispatch sequence), go to IC_IDLE.
  - Unused encodings go to IC_IDLE.

## Timing
- **Reset values:** oIf=0xE0, oIe=0x00, oIme=0, oIrqPending=0, oIrqReq=0, oVector=0x00, EI-pending flag=0, state IC_IDLE.
- **Source to pending:** source rise in cycle N sets rIf in cycle N+1. oIf and oIrqPending reflect it in N+1.
- **Pending to request:** oIrqReq rises the cycle after the qualifying iEof. It stays high until ack or until pending clears.
- **Arbitration window:** in IC_REQ a higher-priority request arriving before ack changes oVector. The vector sampled at ack is the one used.
- **Ack:** in the cycle after ack, oIrqReq=0, the bit is cleared in oIf, and oIme=0.
- **Reset mid-operation:** reset in any state returns all reset values on the next cycle. Captured requests are discarded.

## Structure
- **Shared defines** in aDefinitions.v:
  - state encodings IC_IDLE, IC_REQ, IC_SERVICE;
  - vector constants INT_VBLANK=0x40, INT_LCDSTAT=0x48, INT_TIMER=0x50, INT_SERIAL=0x58, INT_JOYPAD=0x60;
  - IF bit indices.
- **Sub-module** interrupt_priority_encoder: 5-bit masked pending in; outputs a valid flag, a 3-bit index and an 8-bit vector. Combinational, instantiated once.

## Test plan
- Reset, then IE=0x04, then EI followed by two iEof, then 1-cycle iTimer, then iEof → oIrqReq=1 with oVector=0x50. Ack → oIf=0xE0 and oIme=0.
- IE=0x1F, IF written 0x14, IME=1, iEof → oVector=0x50. Before ack, pulse iVBlank → oVector=0x40. Ack → oIf=0xF4.
- IME=0, IE=0x01, iVBlank pulse → oIrqPending=1 and oIrqReq stays 0 across 10 iEof.
- Write IF=0x00 in the same cycle as an iTimer rise → oIf=0xE4 next cycle (hardware set wins).
- In IC_REQ, write IE=0x00 → oIrqReq=0 next cycle and the FSM returns to IC_IDLE. Assert iReset in IC_SERVICE → all outputs at reset values next cycle.
- iEi then iDi before the second iEof → oIme never rises. iReti → oIme=1 next cycle.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared state encodings, interrupt vectors and IF bit positions.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

    localparam logic [7:0] INT_VBLANK  = 8'h40;
    localparam logic [7:0] INT_LCDSTAT = 8'h48;
    localparam logic [7:0] INT_TIMER   = 8'h50;
    localparam logic [7:0] INT_SERIAL  = 8'h58;
    localparam logic [7:0] INT_JOYPAD  = 8'h60;

    localparam int IF_VBLANK  = 0;
    localparam int IF_LCDSTAT = 1;
    localparam int IF_TIMER   = 2;
    localparam int IF_SERIAL  = 3;
    localparam int IF_JOYPAD  = 4;
    localparam int NUM_SRC    = 5;

    // Vectors are spaced 8 bytes apart starting at VBlank.
    function automatic logic [7:0] vector_of(input logic [2:0] idx);
        return INT_VBLANK + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// MCU register bus and CPU dispatch handshake of the interrupt controller.
interface interrupt_controller_if;
    logic       iMcuWeIf;
    logic       iMcuWeIe;
    logic [7:0] iMcuWriteData;
    logic       iEof;
    logic       iEi;
    logic       iDi;
    logic       iReti;
    logic       iIrqAck;
    logic [7:0] oIf;
    logic [7:0] oIe;
    logic       oIme;
    logic       oIrqPending;
    logic       oIrqReq;
    logic [7:0] oVector;

    modport master (
        output iMcuWeIf, iMcuWeIe, iMcuWriteData, iEof, iEi, iDi, iReti, iIrqAck,
        input  oIf, oIe, oIme, oIrqPending, oIrqReq, oVector
    );

    modport slave (
        input  iMcuWeIf, iMcuWeIe, iMcuWriteData, iEof, iEi, iDi, iReti, iIrqAck,
        output oIf, oIe, oIme, oIrqPending, oIrqReq, oVector
    );
endinterface

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority pick of the lowest set pending bit and its dispatch vector.
module interrupt_priority_encoder
    import interrupt_controller_pkg::*;
(
    input  logic [NUM_SRC-1:0] iPending,
    output logic               oValid,
    output logic [2:0]         oIndex,
    output logic [7:0]         oVector
);

    always_comb begin
        oValid  = 1'b0;
        oIndex  = 3'd0;
        oVector = 8'h00;
        // Scan downward so the lowest index set is the one left standing.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (iPending[i]) begin
                oValid = 1'b1;
                oIndex = 3'(i);
            end
        end
        if (oValid) oVector = vector_of(oIndex);
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt flag/enable registers, IME with delayed EI, and CPU dispatch FSM.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic iClock,
    input  logic iReset,
    input  logic iVBlank,
    input  logic iLcdStat,
    input  logic iTimer,
    input  logic iSerial,
    input  logic iJoypad,
    interrupt_controller_if.slave bus
);

    ic_state_e          state_q, state_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic               ime_q, ime_d;
    logic               ei_pend_q, ei_pend_d;
    logic               ei_seen_q, ei_seen_d;
    logic [7:0]         vec_q, vec_d;

    logic [NUM_SRC-1:0] src, rise, pending, clr_mask;
    logic               enc_valid, ack_take;
    logic [2:0]         enc_idx;
    logic [7:0]         enc_vector;

    assign src     = {iJoypad, iSerial, iTimer, iLcdStat, iVBlank};
    assign src_d   = src;
    assign rise    = src & ~src_q;
    assign pending = if_q & ie_q[NUM_SRC-1:0];

    interrupt_priority_encoder u_prio (
        .iPending (pending),
        .oValid   (enc_valid),
        .oIndex   (enc_idx),
        .oVector  (enc_vector)
    );

    assign ack_take = (state_q == IC_REQ) && bus.iIrqAck && enc_valid;
    assign clr_mask = NUM_SRC'(1) << enc_idx;

    always_comb begin
        state_d   = state_q;
        if_d      = if_q;
        ie_d      = ie_q;
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        ei_seen_d = ei_seen_q;
        vec_d     = vec_q;

        // IF: MCU write, then ack clear, then hardware rise (rise always wins).
        if (bus.iMcuWeIf) if_d = bus.iMcuWriteData[NUM_SRC-1:0];
        if (ack_take)     if_d = if_d & ~clr_mask;
        if_d = if_d | rise;

        if (bus.iMcuWeIe) ie_d = bus.iMcuWriteData;

        // EI arms on the first iEof (closing EI) and fires on the next one.
        if (ei_pend_q && bus.iEof) begin
            if (ei_seen_q) begin
                ime_d     = 1'b1;
                ei_pend_d = 1'b0;
                ei_seen_d = 1'b0;
            end else begin
                ei_seen_d = 1'b1;
            end
        end
        if (bus.iEi) begin
            ei_pend_d = 1'b1;
            ei_seen_d = bus.iEof;
        end
        if (bus.iReti) ime_d = 1'b1;
        if (ack_take)  ime_d = 1'b0;
        if (bus.iDi) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
            ei_seen_d = 1'b0;
        end

        case (state_q)
            IC_IDLE:
                if (ime_q && enc_valid && bus.iEof) state_d = IC_REQ;
            IC_REQ:
                if (ack_take) begin
                    vec_d   = enc_vector;
                    state_d = IC_SERVICE;
                end else if (!enc_valid) begin
                    state_d = IC_IDLE;
                end
            IC_SERVICE:
                if (bus.iEof) state_d = IC_IDLE;
            default:
                state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        src_q <= src_d;
        if (iReset) begin
            state_q   <= IC_IDLE;
            if_q      <= '0;
            ie_q      <= 8'h00;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            ei_seen_q <= 1'b0;
            vec_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            if_q      <= if_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            ei_seen_q <= ei_seen_d;
            vec_q     <= vec_d;
        end
    end

    always_comb begin
        bus.oIf         = {3'b111, if_q};
        bus.oIe         = ie_q;
        bus.oIme        = ime_q;
        bus.oIrqPending = enc_valid;
        bus.oIrqReq     = 1'b0;
        bus.oVector     = 8'h00;
        case (state_q)
            IC_REQ: begin
                bus.oIrqReq = enc_valid;
                bus.oVector = enc_vector;
            end
            IC_SERVICE: bus.oVector = vec_q;
            default: ;
        endcase
    end

endmodule
